// File: rtl/rx_rate_change_ctrl_pkg.sv
// Shared definitions for the RX rate-change sequencer: state encodings,
// generation encodings and the GEN to PIPE Rate mapping.
package rx_rate_change_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_WAIT_EIDLE  = 3'd1;
    localparam state_t ST_ASSERT_RATE = 3'd2;
    localparam state_t ST_WAIT_PHY    = 3'd3;
    localparam state_t ST_SETTLE      = 3'd4;
    localparam state_t ST_DONE        = 3'd5;
    localparam state_t ST_FAIL        = 3'd6;

    localparam logic [2:0] GEN1 = 3'd1;
    localparam logic [2:0] GEN2 = 3'd2;
    localparam logic [2:0] GEN3 = 3'd3;

    function automatic logic [2:0] gen_to_rate(input logic [2:0] gen);
        return gen - 3'd1;
    endfunction

endpackage

// File: rtl/rx_rate_change_ctrl_lane_mask.sv
// Active-lane mask latch and sticky PhyStatus accumulator for the rate-change
// sequencer; all_done reports completion including this cycle's PhyStatus.
module rx_lane_mask_collect
    import rx_rate_change_ctrl_pkg::*;
#(
    parameter int MAX_LANES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           lane_count,
    input  logic                 latch_mask,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic [MAX_LANES-1:0] phy_status,
    output logic [MAX_LANES-1:0] mask,
    output logic                 all_done
);

    logic [MAX_LANES-1:0] mask_q, mask_d, new_mask_s;
    logic [MAX_LANES-1:0] sticky_q, sticky_d;
    int                   lane_n_s;

    // Clamp the lane count (0 behaves as 1) and build a thermometer mask.
    always_comb begin
        lane_n_s = int'(lane_count);
        if (lane_n_s == 0) begin
            lane_n_s = 1;
        end else if (lane_n_s > MAX_LANES) begin
            lane_n_s = MAX_LANES;
        end else begin
            lane_n_s = int'(lane_count);
        end
        for (int i = 0; i < MAX_LANES; i++) begin
            new_mask_s[i] = (i < lane_n_s);
        end
    end

    // Next-state for the latched mask and the sticky accumulator.
    always_comb begin
        if (latch_mask) begin
            mask_d = new_mask_s;
        end else begin
            mask_d = mask_q;
        end
        if (clr) begin
            sticky_d = '0;
        end else if (acc_en) begin
            sticky_d = sticky_q | (phy_status & mask_q);
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Mask and sticky state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= '0;
            sticky_q <= '0;
        end else begin
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
        end
    end

    assign mask     = mask_q;
    assign all_done = ((sticky_q | (phy_status & mask_q)) == mask_q);

endmodule

// File: rtl/rx_rate_change_ctrl.sv
// PIPE RX rate-change sequencer: quiesce, wait for electrical idle, switch
// Rate, collect PhyStatus, flush, then publish the new GEN to the RX datapath.
module rx_rate_change_ctrl
    import rx_rate_change_ctrl_pkg::*;
#(
    parameter int MAX_LANES     = 16,
    parameter int MAX_GEN       = 3,
    parameter int EIDLE_TIMEOUT = 1024,
    parameter int PHY_TIMEOUT   = 4096,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_rate_change,
    input  logic [2:0]           target_gen,
    input  logic [4:0]           numberOfDetectedLanes,
    input  logic [MAX_LANES-1:0] RxElectricalIdle,
    input  logic [MAX_LANES-1:0] PhyStatus,
    output logic [2:0]           GEN,
    output logic [2:0]           pipe_rate,
    output logic                 rx_hold,
    output logic                 rx_flush,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [2:0]           state_sts
);

    localparam int TMAX_A  = (EIDLE_TIMEOUT > PHY_TIMEOUT) ? EIDLE_TIMEOUT : PHY_TIMEOUT;
    localparam int TMAX    = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           gen_q, gen_d, target_q, target_d, rate_q, rate_d;
    logic                 hold_q, hold_d, flush_q, flush_d, busy_q, busy_d;
    logic                 done_q, done_d, fail_q, fail_d;
    logic                 latch_mask_s, clr_sticky_s, acc_en_s, phy_all_s, timer_last_s;
    logic [MAX_LANES-1:0] mask_s;

    rx_lane_mask_collect #(.MAX_LANES(MAX_LANES)) u_mask (
        .clk        (clk),
        .reset      (reset),
        .lane_count (numberOfDetectedLanes),
        .latch_mask (latch_mask_s),
        .clr        (clr_sticky_s),
        .acc_en     (acc_en_s),
        .phy_status (PhyStatus),
        .mask       (mask_s),
        .all_done   (phy_all_s)
    );

    assign timer_last_s = (timer_q <= TIMER_W'(1));

    // Sequencer next-state logic; completion is tested before timeout so ties resolve as success.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        gen_d        = gen_q;
        target_d     = target_q;
        rate_d       = rate_q;
        hold_d       = hold_q;
        flush_d      = flush_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        latch_mask_s = 1'b0;
        clr_sticky_s = 1'b0;
        acc_en_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!req_rate_change) begin
                    state_d = ST_IDLE;
                end else if (target_gen == gen_q) begin
                    done_d = 1'b1;
                end else if ((target_gen == 3'd0) || (target_gen > 3'(MAX_GEN))) begin
                    fail_d = 1'b1;
                end else begin
                    target_d     = target_gen;
                    busy_d       = 1'b1;
                    hold_d       = 1'b1;
                    timer_d      = TIMER_W'(EIDLE_TIMEOUT);
                    latch_mask_s = 1'b1;
                    state_d      = ST_WAIT_EIDLE;
                end
            end
            ST_WAIT_EIDLE: begin
                if ((RxElectricalIdle & mask_s) == mask_s) begin
                    state_d = ST_ASSERT_RATE;
                end else if (timer_last_s) begin
                    fail_d  = 1'b1;
                    rate_d  = gen_to_rate(gen_q);
                    flush_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_ASSERT_RATE: begin
                rate_d       = gen_to_rate(target_q);
                flush_d      = 1'b1;
                clr_sticky_s = 1'b1;
                timer_d      = TIMER_W'(PHY_TIMEOUT);
                state_d      = ST_WAIT_PHY;
            end
            ST_WAIT_PHY: begin
                acc_en_s = 1'b1;
                if (phy_all_s) begin
                    gen_d   = target_q;
                    timer_d = TIMER_W'(SETTLE_CYCLES);
                    state_d = ST_SETTLE;
                end else if (timer_last_s) begin
                    fail_d  = 1'b1;
                    rate_d  = gen_to_rate(gen_q);
                    flush_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_last_s) begin
                    flush_d = 1'b0;
                    done_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_DONE, ST_FAIL: begin
                hold_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                rate_d  = gen_to_rate(gen_q);
                hold_d  = 1'b0;
                flush_d = 1'b0;
                busy_d  = 1'b0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            gen_q    <= GEN1;
            target_q <= GEN1;
            rate_q   <= 3'd0;
            hold_q   <= 1'b0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gen_q    <= gen_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            hold_q   <= hold_d;
            flush_q  <= flush_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    assign GEN       = gen_q;
    assign pipe_rate = rate_q;
    assign rx_hold   = hold_q;
    assign rx_flush  = flush_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign state_sts = state_q;

endmodule

// File: doc/rx_rate_change_ctrl.md
Name: rx_rate_change_ctrl

Overview:
- Sequences the receive datapath (PIPE RX, per-lane descramblers, LMC_RX, osDecoder, packet identifier) through a PIPE rate change: Gen1↔Gen2↔Gen3.
- On a speed-change request from the LTSSM side, it:
  - quiesces the RX path;
  - waits for electrical idle on all active lanes;
  - drives the new PIPE Rate and collects PhyStatus completion from every active lane;
  - flushes descrambler/LMC state, then publishes the new GEN to the whole RX datapath.
- It is the single owner of the GEN bus consumed by the RX datapath.

Parameters:
- MAX_LANES, 16, number of PIPE lanes (width of per-lane vectors).
- MAX_GEN, 3, highest supported generation.
- EIDLE_TIMEOUT, 1024, cycles allowed for all active lanes to enter electrical idle.
- PHY_TIMEOUT, 4096, cycles allowed for all PhyStatus completions.
- SETTLE_CYCLES, 8, cycles the flush is held after rate change completes.

Ports:
- clk, input, 1, core clock.
- reset, input, 1, asynchronous active-low reset.
- req_rate_change, input, 1, single-cycle request pulse.
- target_gen, input, 3, requested generation, sampled with req_rate_change.
- numberOfDetectedLanes, input, 5, active lane count.
- RxElectricalIdle, input, MAX_LANES, per-lane PIPE electrical idle.
- PhyStatus, input, MAX_LANES, per-lane PIPE PhyStatus pulses.
- GEN, output, 3, current generation driven to the RX datapath.
- pipe_rate, output, 3, PIPE Rate encoding (GEN-1).
- rx_hold, output, 1, gates RxValid into PIPE_Rx_Data/LMC while 1.
- rx_flush, output, 1, synchronous clear for descrambler/LMC/osDecoder state.
- busy, output, 1, sequence in progress.
- done, output, 1, one-cycle completion pulse.
- fail, output, 1, one-cycle failure pulse.
- state_sts, output, 3, current FSM state encoding.

Behaviour:
- Reset values (asynchronous, active-low): GEN=1, pipe_rate=0, rx_hold=0, rx_flush=0, busy=0, done=0, fail=0, state=IDLE, timers=0, sticky mask=0. Reset mid-sequence aborts immediately with no fail pulse.
- Active mask: lanes 0..N-1, where N=numberOfDetectedLanes. N=0 is treated as 1; N>MAX_LANES is clamped to MAX_LANES. The mask is latched on request acceptance.
- IDLE:
  - req with target_gen==GEN → done pulse next cycle, no other change.
  - req with target_gen==0 or >MAX_GEN → fail pulse next cycle.
  - Otherwise latch target, set busy=1 and rx_hold=1, load eidle timer, go to WAIT_EIDLE.
- req while busy: ignored, with no pulse.
- WAIT_EIDLE:
  - (RxElectricalIdle & mask)==mask → ASSERT_RATE.
  - Timer reaching 0 first → FAIL. A simultaneous idle-complete and timeout resolves as complete.
- ASSERT_RATE (exactly 1 cycle): pipe_rate<=target-1, rx_flush<=1, sticky<=0, load PHY timer → WAIT_PHY. PhyStatus in this cycle is ignored.
- WAIT_PHY:
  - sticky |= PhyStatus & mask each cycle.
  - When (sticky | (PhyStatus & mask))==mask: GEN<=target, load settle counter, → SETTLE.
  - PHY timer reaching 0 → FAIL. Completion wins on a tie.
- SETTLE: counter counts down from SETTLE_CYCLES; on reaching 0, rx_flush<=0 and → DONE. rx_flush is therefore high exactly SETTLE_CYCLES+k cycles, where k = PHY wait length.
- DONE (1 cycle): done=1, rx_hold<=0, busy<=0 → IDLE.
- FAIL (1 cycle): fail=1, pipe_rate<=GEN-1 (restored), rx_flush<=0, rx_hold<=0, busy<=0 → IDLE. GEN is unchanged on fail.
- Latency: with lanes already idle and PhyStatus arriving on the first WAIT_PHY cycle, done asserts 4+SETTLE_CYCLES cycles after the req cycle.
- State encoding: IDLE=0, WAIT_EIDLE=1, ASSERT_RATE=2, WAIT_PHY=3, SETTLE=4, DONE=5, FAIL=6.
- Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state enum, GEN encodings (GEN1=1, GEN2=2, GEN3=3), gen_to_rate function.
- One sub-module, rx_lane_mask_collect: builds the active mask from the lane count, and holds the sticky PhyStatus accumulator with clear and all-done output.
- The FSM and timers live in the top module.

Test Plan:
- Basic change: N=4, lanes 0-3 idle, PhyStatus=16'h000F on the first WAIT_PHY cycle, req target=2 from GEN=1 → pipe_rate=1, GEN=2, done at req+12 cycles (SETTLE_CYCLES=8), rx_flush high 9 cycles.
- Staggered PhyStatus: N=4, pulses on lanes 0, 2, 1, 3 in separate cycles; lanes 4-15 never pulse → completes after lane 3; non-active lanes ignored.
- Timeout: N=2, lane 1 never reports PhyStatus → fail after PHY_TIMEOUT cycles; pipe_rate back to 0, GEN stays 1, rx_hold=0.
- Invalid/no-op: target=1 at GEN=1 → done next cycle, no flush. target=5 → fail next cycle. req during WAIT_PHY → ignored.
- Eidle timeout: lane 0 never idle → fail after EIDLE_TIMEOUT, pipe_rate never changed.
- Reset mid-sequence: assert reset in SETTLE → all outputs at reset values asynchronously; GEN=1, no done/fail pulse.
